// File: rtl/dmem_pkg.sv
// Shared types and lane helpers for the handshaked data-memory responder.
// The functions do the byte/half steering and extension that the top and bench rely on.
package dmem_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RD,
      RESP
   } state_t;

   typedef enum logic [1:0] {
      BYTE,
      HALF,
      WORD
   } size_t;

   // Picks the addressed byte/half out of a word and widens it to 32 bits.
   function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                                input logic [1:0]  offset,
                                                input size_t       size,
                                                input logic        is_signed);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      b = word[{offset, 3'b000} +: 8];
      h = offset[1] ? word[31:16] : word[15:0];
      case (size)
         BYTE:    r = {{24{is_signed & b[7]}}, b};
         HALF:    r = {{16{is_signed & h[15]}}, h};
         default: r = word;
      endcase
      return r;
   endfunction

   function automatic logic [3:0] byte_enable(input logic [1:0] offset,
                                              input size_t      size);
      logic [3:0] be;
      case (size)
         BYTE:    be = 4'b0001 << offset;
         HALF:    be = offset[1] ? 4'b1100 : 4'b0011;
         default: be = 4'b1111;
      endcase
      return be;
   endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bus between the core's load/store unit and the data memory.
interface dmem_responder_if;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        sb, sh, sw;
   logic        lb, lh, lw, lbu, lhu;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_err;

   modport master (
      output req_valid, req_addr, req_wdata, sb, sh, sw, lb, lh, lw, lbu, lhu, resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_addr, req_wdata, sb, sh, sw, lb, lh, lw, lbu, lhu, resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface

// File: rtl/dmem_sram_be.sv
// Word-organised storage with per-byte write enables and a registered read port.
module dmem_sram_be #(
   parameter  int DEPTH_WORDS = 256,
   localparam int AW          = $clog2(DEPTH_WORDS)
) (
   input  logic          i_clk,
   input  logic          i_we,
   input  logic          i_re,
   input  logic [3:0]    i_be,
   input  logic [AW-1:0] i_addr,
   input  logic [31:0]   i_wdata,
   output logic [31:0]   o_rdata
);

   logic [31:0] r_mem [DEPTH_WORDS];
   logic [31:0] r_rdata;

   // Contents are deliberately not reset; read data holds until the next read.
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         for (int b = 0; b < 4; b++) begin
            if (i_be[b]) r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
         end
      end
      if (i_re) r_rdata <= r_mem[i_addr];
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// Responder side of the core's load/store access: checks each request, writes stores at
// the accept edge, reads loads one cycle later, and holds a single response until taken.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter  int DEPTH_WORDS = 256,
   localparam int AW          = $clog2(DEPTH_WORDS)
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   dmem_responder_if.slave s_bus
);

   state_t        r_state, w_next;
   logic [AW-1:0] r_wordIdx;
   logic [1:0]    r_offset;
   size_t         r_size;
   logic          r_signed, r_isLoad, r_err;

   logic [7:0]    w_flags;
   logic          w_illegal, w_misaligned, w_oob, w_err;
   logic          w_isStore, w_signed, w_accept, w_we, w_re;
   size_t         w_size;
   logic [AW-1:0] w_reqIdx, w_ramAddr;
   logic [31:0]   w_wdata, w_ramRdata;

   assign w_flags      = {s_bus.sb, s_bus.sh, s_bus.sw, s_bus.lb,
                          s_bus.lh, s_bus.lw, s_bus.lbu, s_bus.lhu};
   assign w_illegal    = ($countones(w_flags) != 1);
   assign w_misaligned = ((s_bus.sh | s_bus.lh | s_bus.lhu) & s_bus.req_addr[0])
                       | ((s_bus.sw | s_bus.lw) & (s_bus.req_addr[1:0] != 2'b00));
   // DEPTH_WORDS is a power of two, so any set bit above the word index is out of range.
   assign w_oob        = |s_bus.req_addr[31:AW+2];
   assign w_err        = w_illegal | w_misaligned | w_oob;
   assign w_isStore    = s_bus.sb | s_bus.sh | s_bus.sw;
   assign w_signed     = s_bus.lb | s_bus.lh;
   assign w_reqIdx     = s_bus.req_addr[AW+1:2];
   assign w_accept     = s_bus.req_valid & (r_state == IDLE) & i_rst_n;

   always_comb begin
      w_size  = WORD;
      w_wdata = s_bus.req_wdata;
      if (s_bus.sb | s_bus.lb | s_bus.lbu) begin
         w_size  = BYTE;
         w_wdata = {4{s_bus.req_wdata[7:0]}};
      end else if (s_bus.sh | s_bus.lh | s_bus.lhu) begin
         w_size  = HALF;
         w_wdata = {2{s_bus.req_wdata[15:0]}};
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      w_we   = 1'b0;
      w_re   = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_we   = w_isStore & ~w_err;
               w_next = (w_err | w_isStore) ? RESP : RD;
            end
         end
         RD: begin
            w_re   = 1'b1;
            w_next = RESP;
         end
         RESP: begin
            if (s_bus.resp_ready) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   // Load context captured at accept so the request inputs are free to change afterwards.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wordIdx <= '0;
         r_offset  <= 2'b00;
         r_size    <= WORD;
         r_signed  <= 1'b0;
         r_isLoad  <= 1'b0;
         r_err     <= 1'b0;
      end else if (w_accept) begin
         r_wordIdx <= w_reqIdx;
         r_offset  <= s_bus.req_addr[1:0];
         r_size    <= w_size;
         r_signed  <= w_signed;
         r_isLoad  <= ~w_err & ~w_isStore;
         r_err     <= w_err;
      end
   end

   assign w_ramAddr = (r_state == RD) ? r_wordIdx : w_reqIdx;

   dmem_sram_be #(.DEPTH_WORDS(DEPTH_WORDS)) u_sram (
      .i_clk   (i_clk),
      .i_we    (w_we),
      .i_re    (w_re),
      .i_be    (byte_enable(s_bus.req_addr[1:0], w_size)),
      .i_addr  (w_ramAddr),
      .i_wdata (w_wdata),
      .o_rdata (w_ramRdata)
   );

   assign s_bus.req_ready  = (r_state == IDLE) & i_rst_n;
   assign s_bus.resp_valid = (r_state == RESP);
   assign s_bus.resp_err   = (r_state == RESP) & r_err;
   assign s_bus.resp_rdata = ((r_state == RESP) && r_isLoad)
                           ? lane_extract(w_ramRdata, r_offset, r_size, r_signed) : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: hand-computed loads/stores, error cases, back-pressure
// and reset mid-transaction, all checked with immediate assertions.
module tb_dmem_responder;

   localparam logic [7:0] F_SB  = 8'h80;
   localparam logic [7:0] F_SH  = 8'h40;
   localparam logic [7:0] F_SW  = 8'h20;
   localparam logic [7:0] F_LB  = 8'h10;
   localparam logic [7:0] F_LH  = 8'h08;
   localparam logic [7:0] F_LW  = 8'h04;
   localparam logic [7:0] F_LBU = 8'h02;
   localparam logic [7:0] F_LHU = 8'h01;

   logic clk;
   logic rst_n;
   int   nCompared;
   int   nMismatched;

   dmem_responder_if bus ();

   dmem_responder #(.DEPTH_WORDS(256)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .s_bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      nCompared++;
      assert (observed === expected) else begin
         nMismatched++;
         $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   task automatic setFlags(input logic [7:0] f);
      {bus.sb, bus.sh, bus.sw, bus.lb, bus.lh, bus.lw, bus.lbu, bus.lhu} = f;
   endtask

   // One full transaction: present, accept, wait (bounded) for the response, take it.
   task automatic applyStimulus(input logic [7:0] flags, input logic [31:0] addr,
                                input logic [31:0] wdata, output int lat,
                                output logic [31:0] rdata, output logic err);
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_addr  = addr;
      bus.req_wdata = wdata;
      setFlags(flags);
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      bus.req_addr  = $urandom;
      bus.req_wdata = $urandom;
      setFlags(8'h00);
      lat = 1;
      while (bus.resp_valid !== 1'b1 && lat < 8) begin
         @(posedge clk); #1;
         lat++;
      end
      rdata = bus.resp_rdata;
      err   = bus.resp_err;
      @(negedge clk) bus.resp_ready = 1'b1;
      @(posedge clk); #1;
      bus.resp_ready = 1'b0;
   endtask

   task automatic checkTxn(input string tag, input logic [7:0] flags, input logic [31:0] addr,
                           input logic [31:0] wdata, input int expLat,
                           input logic [31:0] expRdata, input logic expErr);
      int          lat;
      logic [31:0] rdata;
      logic        err;
      applyStimulus(flags, addr, wdata, lat, rdata, err);
      checkOutput({tag, " latency"}, 32'(lat), 32'(expLat));
      checkOutput({tag, " rdata"}, rdata, expRdata);
      checkOutput({tag, " err"}, {31'd0, err}, {31'd0, expErr});
   endtask

   initial begin
      nCompared       = 0;
      nMismatched     = 0;
      rst_n           = 1'b0;
      bus.req_valid   = 1'b0;
      bus.req_addr    = '0;
      bus.req_wdata   = '0;
      bus.resp_ready  = 1'b0;
      setFlags(8'h00);

      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset req_ready", {31'd0, bus.req_ready}, 32'd0);
      checkOutput("reset resp_valid", {31'd0, bus.resp_valid}, 32'd0);
      checkOutput("reset resp_rdata", bus.resp_rdata, 32'd0);
      checkOutput("reset resp_err", {31'd0, bus.resp_err}, 32'd0);
      @(negedge clk) rst_n = 1'b1;
      #1;
      checkOutput("idle req_ready", {31'd0, bus.req_ready}, 32'd1);

      $display("[TB] word store and load");
      checkTxn("sw 0x10", F_SW, 32'h10, 32'hDEADBEEF, 1, 32'h0, 1'b0);
      checkTxn("lw 0x10", F_LW, 32'h10, 32'h0, 2, 32'hDEADBEEF, 1'b0);

      $display("[TB] byte store and byte loads");
      checkTxn("sb 0x11", F_SB, 32'h11, 32'h000000A5, 1, 32'h0, 1'b0);
      checkTxn("lw 0x10 after sb", F_LW, 32'h10, 32'h0, 2, 32'hDEADA5EF, 1'b0);
      checkTxn("lb 0x11", F_LB, 32'h11, 32'h0, 2, 32'hFFFFFFA5, 1'b0);
      checkTxn("lbu 0x11", F_LBU, 32'h11, 32'h0, 2, 32'h000000A5, 1'b0);
      checkTxn("lbu 0x13", F_LBU, 32'h13, 32'h0, 2, 32'h000000DE, 1'b0);

      $display("[TB] half store and half loads");
      checkTxn("sw 0x20", F_SW, 32'h20, 32'h12345678, 1, 32'h0, 1'b0);
      checkTxn("sh 0x22", F_SH, 32'h22, 32'hFFFF8001, 1, 32'h0, 1'b0);
      checkTxn("lh 0x22", F_LH, 32'h22, 32'h0, 2, 32'hFFFF8001, 1'b0);
      checkTxn("lhu 0x22", F_LHU, 32'h22, 32'h0, 2, 32'h00008001, 1'b0);
      checkTxn("lw 0x20 after sh", F_LW, 32'h20, 32'h0, 2, 32'h80015678, 1'b0);
      checkTxn("lh 0x20", F_LH, 32'h20, 32'h0, 2, 32'h00005678, 1'b0);

      $display("[TB] error requests and last word");
      checkTxn("sw 0x0", F_SW, 32'h0, 32'h11111111, 1, 32'h0, 1'b0);
      checkTxn("sw 0x3FC", F_SW, 32'h3FC, 32'hA5A5C3C3, 1, 32'h0, 1'b0);
      checkTxn("lw 0x3FC", F_LW, 32'h3FC, 32'h0, 2, 32'hA5A5C3C3, 1'b0);
      checkTxn("lw 0x13 misaligned", F_LW, 32'h13, 32'h0, 1, 32'h0, 1'b1);
      checkTxn("sh 0x21 misaligned", F_SH, 32'h21, 32'h0000FFFF, 1, 32'h0, 1'b1);
      checkTxn("sw 0x400 range", F_SW, 32'h400, 32'h99999999, 1, 32'h0, 1'b1);
      checkTxn("sb+lw illegal", F_SB | F_LW, 32'h10, 32'h00000077, 1, 32'h0, 1'b1);
      checkTxn("no flag illegal", 8'h00, 32'h10, 32'h0, 1, 32'h0, 1'b1);
      checkTxn("lw 0x10 intact", F_LW, 32'h10, 32'h0, 2, 32'hDEADA5EF, 1'b0);
      checkTxn("lw 0x20 intact", F_LW, 32'h20, 32'h0, 2, 32'h80015678, 1'b0);
      checkTxn("lw 0x0 intact", F_LW, 32'h0, 32'h0, 2, 32'h11111111, 1'b0);

      $display("[TB] response back-pressure");
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_addr  = 32'h10;
      setFlags(F_LW);
      @(posedge clk); #1;
      bus.req_addr  = 32'h50;
      bus.req_wdata = 32'hCAFEF00D;
      setFlags(F_SW);
      @(posedge clk); #1;
      for (int i = 0; i < 5; i++) begin
         checkOutput("hold resp_valid", {31'd0, bus.resp_valid}, 32'd1);
         checkOutput("hold resp_rdata", bus.resp_rdata, 32'hDEADA5EF);
         checkOutput("hold resp_err", {31'd0, bus.resp_err}, 32'd0);
         checkOutput("hold req_ready", {31'd0, bus.req_ready}, 32'd0);
         @(posedge clk); #1;
      end
      @(negedge clk) bus.resp_ready = 1'b1;
      @(posedge clk); #1;
      bus.resp_ready = 1'b0;
      checkOutput("post handshake resp_valid", {31'd0, bus.resp_valid}, 32'd0);
      checkOutput("post handshake req_ready", {31'd0, bus.req_ready}, 32'd1);
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      setFlags(8'h00);
      checkOutput("queued sw resp_valid", {31'd0, bus.resp_valid}, 32'd1);
      checkOutput("queued sw resp_err", {31'd0, bus.resp_err}, 32'd0);
      @(negedge clk) bus.resp_ready = 1'b1;
      @(posedge clk); #1;
      bus.resp_ready = 1'b0;
      checkTxn("lw 0x50", F_LW, 32'h50, 32'h0, 2, 32'hCAFEF00D, 1'b0);

      $display("[TB] reset during load read");
      checkTxn("sw 0x40", F_SW, 32'h40, 32'h0BADF00D, 1, 32'h0, 1'b0);
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_addr  = 32'h40;
      setFlags(F_LW);
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      setFlags(8'h00);
      rst_n = 1'b0;
      #1;
      checkOutput("mid-reset resp_valid", {31'd0, bus.resp_valid}, 32'd0);
      checkOutput("mid-reset req_ready", {31'd0, bus.req_ready}, 32'd0);
      checkOutput("mid-reset resp_rdata", bus.resp_rdata, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("after reset resp_valid", {31'd0, bus.resp_valid}, 32'd0);
      checkOutput("after reset req_ready", {31'd0, bus.req_ready}, 32'd1);
      checkTxn("lw 0x40 after reset", F_LW, 32'h40, 32'h0, 2, 32'h0BADF00D, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
